fifo_n_level: RTL

Parametrised-depth synchronous FIFO: the sized successor to the fixed depth-2 FIFO used between BSV-generated pipeline stages. It keeps the same ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake so existing producers and consumers connect unchanged. It adds a configurable depth (non-power-of-two allowed), a registered occupancy count, an almost-full threshold flag, and optional sticky overflow/underflow error flags. It sits in the primitives library and is instantiated wherever a stage needs more than two entries of elasticity.

---
 rtl/fifo_n_level_if.sv | 29 ++
 rtl/fifo_n_level.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_n_level_if.sv
// Handshake bundle for fifo_n_level: producer/consumer side is the master, the FIFO is the slave.
interface fifo_n_level_if #(
  parameter int width = 1,
  parameter int depth = 4
);
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] D_IN;
  logic             ENQ;
  logic             FULL_N;
  logic [width-1:0] D_OUT;
  logic             DEQ;
  logic             EMPTY_N;
  logic             CLR;
  logic [CW-1:0]    COUNT;
  logic             ALMOST_FULL;
  logic             OVF;
  logic             UDF;

  modport master (
    output D_IN, ENQ, DEQ, CLR,
    input  FULL_N, D_OUT, EMPTY_N, COUNT, ALMOST_FULL, OVF, UDF
  );

  modport slave (
    input  D_IN, ENQ, DEQ, CLR,
    output FULL_N, D_OUT, EMPTY_N, COUNT, ALMOST_FULL, OVF, UDF
  );
endinterface

// File: rtl/fifo_n_level.sv
// Parametrised-depth synchronous FIFO with registered COUNT/FULL_N/EMPTY_N/ALMOST_FULL.
// Define FIFO_N_LEVEL_ERR_FLAGS_EN to get sticky OVF/UDF registers (tied to 0 otherwise).
module fifo_n_level #(
  parameter int width     = 1,
  parameter int depth     = 4,
  parameter int afull_lvl = depth - 1,
  parameter int guarded   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  fifo_n_level_if.slave q
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AFULL_C = CW'(afull_lvl);
  localparam logic [PW-1:0] LAST_C  = PW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count, count_next;
  logic             full_n, empty_n, almost_full;
  logic             enq_acc, deq_acc, ovf_ev, udf_ev;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Handshake: an ENQ is taken when FULL_N=1 (or, unguarded, when full but a DEQ
  // drains a word that same edge); a DEQ is taken when EMPTY_N=1. There is no
  // empty bypass, so ENQ+DEQ on an empty queue stores the word and rejects the DEQ.
  always_comb begin
    enq_acc    = q.ENQ && (full_n || ((guarded == 0) && q.DEQ && empty_n));
    deq_acc    = q.DEQ && empty_n;
    ovf_ev     = q.ENQ && !enq_acc;
    udf_ev     = q.DEQ && !deq_acc;
    count_next = count;
    if (enq_acc && !deq_acc)      count_next = count + CW'(1);
    else if (!enq_acc && deq_acc) count_next = count - CW'(1);
  end

  // Flags are registered from count_next so they track the post-edge occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      full_n      <= 1'b1;
      empty_n     <= 1'b0;
      almost_full <= 1'b0;
    end else if (q.CLR) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      full_n      <= 1'b1;
      empty_n     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (enq_acc) wp <= ptr_inc(wp);
      if (deq_acc) rp <= ptr_inc(rp);
      count       <= count_next;
      full_n      <= (count_next != DEPTH_C);
      empty_n     <= (count_next != '0);
      almost_full <= (count_next >= AFULL_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && !q.CLR && enq_acc) mem[wp] <= q.D_IN;
  end

`ifdef FIFO_N_LEVEL_ERR_FLAGS_EN
  logic ovf, udf;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (q.CLR) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_ev) ovf <= 1'b1;
      if (udf_ev) udf <= 1'b1;
    end
  end

  assign q.OVF = ovf;
  assign q.UDF = udf;
`else
  assign q.OVF = 1'b0;
  assign q.UDF = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RST && !q.CLR && ovf_ev) $warning("%m: enqueuing to full fifo, word dropped");
    if (RST && !q.CLR && udf_ev) $warning("%m: dequeuing from empty fifo");
  end
`endif

  assign q.D_OUT       = mem[rp];
  assign q.FULL_N      = full_n;
  assign q.EMPTY_N     = empty_n;
  assign q.COUNT       = count;
  assign q.ALMOST_FULL = almost_full;
endmodule
